// File: rtl/bitorder_param_if.sv
// -----------------------------------------------------------------------------
// bitorder_param_if
// Symbol-stream bundle between the PHY symbol side and the reorder block.
//   axiiv     : input symbol valid (a low cycle ends the current frame)
//   axiid     : input symbol, SYM_W bits, first received symbol is index 0
//   mode      : 1 = reverse symbols within a word, 0 = pass through
//   axiov     : output symbol valid
//   axiod     : output symbol, SYM_W bits
//   axiol     : marks the last output symbol of a frame
//   frame_err : one-cycle pulse when a frame ends on a partial word
// master drives the input stream, slave is the reorder block.
// -----------------------------------------------------------------------------
interface bitorder_param_if #(
  parameter int SYM_W = 2
);
  logic             axiiv;
  logic [SYM_W-1:0] axiid;
  logic             mode;
  logic             axiov;
  logic [SYM_W-1:0] axiod;
  logic             axiol;
  logic             frame_err;

  modport master (
    output axiiv, axiid, mode,
    input  axiov, axiod, axiol, frame_err
  );

  modport slave (
    input  axiiv, axiid, mode,
    output axiov, axiod, axiol, frame_err
  );
endinterface

// File: rtl/bitorder_param.sv
// -----------------------------------------------------------------------------
// bitorder_param
// Receive-path symbol-order converter. Groups SYM_W-bit symbols into WORD_W-bit
// words and re-emits each word with its symbols reversed (mode=1) or in the
// original order (mode=0). Two word buffers are used ping-pong so one fills
// while the other drains; output follows the input by a fixed latency.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : bitorder_param_if.slave (axiiv/axiid/mode in,
//           axiov/axiod/axiol/frame_err out, all outputs registered)
// Parameters:
//   SYM_W  : symbol width, 1, 2 or 4
//   WORD_W : word width, a multiple of SYM_W with WORD_W/SYM_W >= 2
// -----------------------------------------------------------------------------
module bitorder_param #(
  parameter int SYM_W  = 2,
  parameter int WORD_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  bitorder_param_if.slave bus
);

  localparam int N  = WORD_W / SYM_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Word storage and per-buffer status
  logic [SYM_W-1:0] r_buf [2][N];
  logic [1:0]       r_full;
  logic [1:0]       r_mode;
  logic [1:0]       r_last;

  // Fill side
  logic             r_fill_buf;
  logic [CW-1:0]    r_fill_cnt;
  logic             r_prev_v;
  logic             r_frame_mode;
  logic             r_have_word;
  logic             r_prev_buf;

  // Drain side
  logic             r_drain_buf;
  logic [CW-1:0]    r_drain_cnt;

  // Registered outputs
  logic             r_axiov;
  logic [SYM_W-1:0] r_axiod;
  logic             r_axiol;
  logic             r_frame_err;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_start;
  logic             w_cur_mode;
  logic             w_word_done;
  logic             w_frame_end;
  logic             w_partial;
  logic             w_drain_en;
  logic             w_drain_final;
  logic [CW-1:0]    w_slot;
  logic             w_tag_now;
  logic             w_last_out;

  assign w_start     = bus.axiiv & ~r_prev_v;
  // mode is only honoured on the first symbol of a frame
  assign w_cur_mode  = w_start ? bus.mode : r_frame_mode;
  assign w_word_done = bus.axiiv & (r_fill_cnt == LAST_SLOT);
  assign w_frame_end = ~bus.axiiv & r_prev_v;
  assign w_partial   = w_frame_end & (r_fill_cnt != CNT_ZERO);

  assign w_drain_en    = r_full[r_drain_buf];
  assign w_drain_final = w_drain_en & (r_drain_cnt == LAST_SLOT);
  assign w_slot        = r_mode[r_drain_buf] ? (LAST_SLOT - r_drain_cnt) : r_drain_cnt;

  // The last complete word is always the one draining when the frame ends.
  // When a partial word of N-1 symbols is discarded, the end edge coincides
  // with that word's final drain symbol, so the tag has to be applied
  // combinationally as well as stored.
  assign w_tag_now  = w_frame_end & r_have_word & (r_prev_buf == r_drain_buf);
  assign w_last_out = w_drain_final & (r_last[r_drain_buf] | w_tag_now);

  assign bus.axiov     = r_axiov;
  assign bus.axiod     = r_axiod;
  assign bus.axiol     = r_axiol;
  assign bus.frame_err = r_frame_err;

  // Fill side: write symbols, advance fill pointer, track frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < N; s++) begin
          r_buf[b][s] <= {SYM_W{1'b0}};
        end
      end
      r_mode       <= 2'b00;
      r_fill_buf   <= 1'b0;
      r_fill_cnt   <= CNT_ZERO;
      r_prev_v     <= 1'b0;
      r_frame_mode <= 1'b0;
      r_have_word  <= 1'b0;
      r_prev_buf   <= 1'b0;
    end else begin
      r_prev_v <= bus.axiiv;
      if (w_start) begin
        r_frame_mode <= bus.mode;
      end
      if (bus.axiiv) begin
        r_buf[r_fill_buf][r_fill_cnt] <= bus.axiid;
        if (w_word_done) begin
          r_mode[r_fill_buf] <= w_cur_mode;
          r_prev_buf         <= r_fill_buf;
          r_have_word        <= 1'b1;
          r_fill_buf         <= ~r_fill_buf;
          r_fill_cnt         <= CNT_ZERO;
        end else begin
          r_fill_cnt <= r_fill_cnt + CNT_ONE;
        end
      end else begin
        // any partial word is dropped when the frame ends
        r_fill_cnt  <= CNT_ZERO;
        r_have_word <= 1'b0;
      end
    end
  end

  // Buffer status: full on word completion, last-tag on frame end, release after drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 2'b00;
      r_last <= 2'b00;
    end else begin
      if (w_word_done) begin
        r_full[r_fill_buf] <= 1'b1;
        r_last[r_fill_buf] <= 1'b0;
      end
      if (w_frame_end && r_have_word) begin
        r_last[r_prev_buf] <= 1'b1;
      end
      // release wins over a same-cycle tag on the buffer being emptied
      if (w_drain_final) begin
        r_full[r_drain_buf] <= 1'b0;
        r_last[r_drain_buf] <= 1'b0;
      end
    end
  end

  // Drain side: step through the full buffer one symbol per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_buf <= 1'b0;
      r_drain_cnt <= CNT_ZERO;
    end else begin
      if (w_drain_en) begin
        if (w_drain_final) begin
          r_drain_cnt <= CNT_ZERO;
          r_drain_buf <= ~r_drain_buf;
        end else begin
          r_drain_cnt <= r_drain_cnt + CNT_ONE;
        end
      end
    end
  end

  // Output registers; data is forced to zero outside a drain window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_axiov     <= 1'b0;
      r_axiod     <= {SYM_W{1'b0}};
      r_axiol     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_axiov     <= w_drain_en;
      r_axiod     <= w_drain_en ? r_buf[r_drain_buf][w_slot] : {SYM_W{1'b0}};
      r_axiol     <= w_last_out;
      r_frame_err <= w_partial;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control next-state: tracks whether the block is filling, streaming or draining
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.axiiv) begin
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (w_word_done) begin
          w_state_nxt = ST_STREAM;
        end else if (w_frame_end) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_STREAM: begin
        if (w_frame_end) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (w_word_done) begin
          w_state_nxt = ST_STREAM;
        end else if (w_drain_final) begin
          if (bus.axiiv) begin
            w_state_nxt = ST_FILL;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
